// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and default widths for the two-port data memory arbiter.
package data_memory_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dm_state_t;

  // One requester's operands. The field widths follow the package defaults,
  // so the top-level width parameters are expected to keep those defaults.
  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester and memory-side bundle for the data memory arbiter.
// The slave modport belongs to the arbiter. The master modport belongs to
// whatever drives the requests and models the memory.
interface data_memory_arbiter_if
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              memWrite;
  logic              memRead;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] escreveDado;
  logic [DATA_W-1:0] leDado;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, leDado,
    output ack0, ack1, rdata0, rdata1, memWrite, memRead, endereco, escreveDado
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, leDado,
    input  ack0, ack1, rdata0, rdata1, memWrite, memRead, endereco, escreveDado
  );

endinterface

// File: rtl/data_memory_arbiter_rr.sv
// Combinational two-way winner select.
// When only one port is requesting, that port wins. When both are
// requesting, the port that did not win last time is chosen, or port 0 is
// chosen when fixed priority is selected.
module data_memory_arbiter_rr #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req_i,
  input  logic       lastGrant_i,
  output logic       grantValid_o,
  output logic       grant_o
);

  // Pick the winner from the request pair and the previous grant.
  always_comb begin
    grantValid_o = |req_i;
    grant_o      = 1'b0;
    case (req_i)
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = FIXED_PRIO ? 1'b0 : ~lastGrant_i;
      default: grant_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Sequencer in front of the single-port data memory. The memory reads on
// the negative edge and writes on the positive edge.
// Each access takes IDLE -> ACCESS -> RESP. The winner's operands are
// registered straight onto the memory-side outputs, so the memory sees
// stable signals for the whole ACCESS cycle.
module data_memory_arbiter
  import data_memory_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  data_memory_arbiter_if.slave  bus
);

  dm_state_t         state_q;
  logic              lastGrant_q;
  logic              grant_q;
  logic              ack0_q;
  logic              ack1_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              memWrite_q;
  logic              memRead_q;
  logic [ADDR_W-1:0] endereco_q;
  logic [DATA_W-1:0] escreveDado_q;

  logic              grantValid_d;
  logic              grant_d;
  dm_req_t           winReq_d;

  data_memory_arbiter_rr #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr (
    .req_i        ({bus.req1, bus.req0}),
    .lastGrant_i  (lastGrant_q),
    .grantValid_o (grantValid_d),
    .grant_o      (grant_d)
  );

  // Route the winning port's operands. Only this selection is sampled, so
  // the losing port's operands are never captured.
  always_comb begin
    winReq_d = {bus.we0, bus.addr0, bus.wdata0};
    if (grant_d) begin
      winReq_d = {bus.we1, bus.addr1, bus.wdata1};
    end
  end

  // Main sequencer. It drives all registered outputs and arbitrates in IDLE.
  // An async reset aborts an in-flight write because memWrite drops before
  // the closing edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      lastGrant_q   <= 1'b1;
      grant_q       <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      memWrite_q    <= 1'b0;
      memRead_q     <= 1'b0;
      endereco_q    <= '0;
      escreveDado_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          memWrite_q <= 1'b0;
          memRead_q  <= 1'b0;
          if (grantValid_d) begin
            grant_q       <= grant_d;
            lastGrant_q   <= grant_d;
            memWrite_q    <= winReq_d.we;
            memRead_q     <= ~winReq_d.we;
            endereco_q    <= winReq_d.addr;
            escreveDado_q <= winReq_d.wdata;
            state_q       <= ACCESS;
          end
        end
        ACCESS: begin
          memWrite_q <= 1'b0;
          memRead_q  <= 1'b0;
          if (memRead_q) begin
            if (grant_q) begin
              rdata1_q <= bus.leDado;
            end else begin
              rdata0_q <= bus.leDado;
            end
          end
          if (grant_q) begin
            ack1_q <= 1'b1;
          end else begin
            ack0_q <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          ack0_q     <= 1'b0;
          ack1_q     <= 1'b0;
          memWrite_q <= 1'b0;
          memRead_q  <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.memWrite    = memWrite_q;
  assign bus.memRead     = memRead_q;
  assign bus.endereco    = endereco_q;
  assign bus.escreveDado = escreveDado_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter. dutA is round-robin and is backed by a RAM
// model. dutB uses fixed priority and is backed by a ROM model that returns
// addr+1.
module tb_data_memory_arbiter;
  import data_memory_arbiter_pkg::*;

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    logic       we;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int passCount  = 0;
  int checkCount = 0;
  int ackB1Count = 0;

  exp_t qA0[$];
  exp_t qA1[$];
  exp_t qB0[$];

  logic [7:0] memA [256];

  data_memory_arbiter_if busA ();
  data_memory_arbiter_if busB ();

  data_memory_arbiter #(.FIXED_PRIO(1'b0)) dutA (
    .clock (clock),
    .reset (reset),
    .bus   (busA.slave)
  );

  data_memory_arbiter #(.FIXED_PRIO(1'b1)) dutB (
    .clock (clock),
    .reset (reset),
    .bus   (busB.slave)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // RAM model for dutA: writes commit on the positive edge.
  always @(posedge clock) begin
    if (busA.memWrite) memA[busA.endereco] <= busA.escreveDado;
  end

  // RAM model for dutA: reads update on the negative edge.
  always @(negedge clock) begin
    if (busA.memRead) busA.leDado <= memA[busA.endereco];
  end

  // ROM model for dutB: mem[a] = a + 1.
  always @(negedge clock) begin
    if (busB.memRead) busB.leDado <= busB.endereco + 8'd1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic driveA(input int port, input logic req, input logic we,
                        input logic [7:0] addr, input logic [7:0] wdata);
    if (port == 0) begin
      busA.req0 = req; busA.we0 = we; busA.addr0 = addr; busA.wdata0 = wdata;
    end else begin
      busA.req1 = req; busA.we1 = we; busA.addr1 = addr; busA.wdata1 = wdata;
    end
  endtask

  task automatic pushA(input int port, input logic we, input logic [7:0] data);
    exp_t e;
    e.we = we;
    e.data = data;
    if (port == 0) qA0.push_back(e);
    else qA1.push_back(e);
  endtask

  // Runs a single-port transaction on dutA and checks that ack arrives on
  // the second clock edge.
  task automatic applyStimulus(input vec_t v);
    int  cycles;
    logic got;
    pushA(v.port, v.we, v.exp);
    @(posedge clock); #1;
    driveA(v.port, 1'b1, v.we, v.addr, v.wdata);
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 10) begin
      @(posedge clock); #1;
      cycles++;
      got = (v.port == 0) ? busA.ack0 : busA.ack1;
    end
    checkOutput($sformatf("latency p%0d a%02h", v.port, v.addr), got ? cycles : 99, 2);
    driveA(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic pulseReset();
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Scoreboard monitor. On each ack it pops the expected entry for that
  // port. A read compares rdata against the entry. A write checks that
  // rdata still holds the last read value.
  initial begin : monitor
    exp_t e;
    logic [7:0] lastA0, lastA1, lastB0;
    lastA0 = 0; lastA1 = 0; lastB0 = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        lastA0 = 0; lastA1 = 0; lastB0 = 0;
      end
      if (busA.ack0) begin
        checkOutput("ackA0 expected", 32'(qA0.size() != 0), 1);
        if (qA0.size() != 0) begin
          e = qA0.pop_front();
          if (!e.we) begin
            checkOutput("rdataA0", busA.rdata0, e.data);
            lastA0 = e.data;
          end else checkOutput("rdataA0 held on write", busA.rdata0, lastA0);
        end
      end
      if (busA.ack1) begin
        checkOutput("ackA1 expected", 32'(qA1.size() != 0), 1);
        if (qA1.size() != 0) begin
          e = qA1.pop_front();
          if (!e.we) begin
            checkOutput("rdataA1", busA.rdata1, e.data);
            lastA1 = e.data;
          end else checkOutput("rdataA1 held on write", busA.rdata1, lastA1);
        end
      end
      if (busB.ack0) begin
        checkOutput("ackB0 expected", 32'(qB0.size() != 0), 1);
        if (qB0.size() != 0) begin
          e = qB0.pop_front();
          checkOutput("rdataB0", busB.rdata0, e.data);
          lastB0 = e.data;
        end
      end
      if (busB.ack1) ackB1Count++;
    end
  end

  initial begin : stimulus
    vec_t vecs[12];
    int   cycles;
    int   port;
    int   firstPort;
    int   ack0Seen;
    logic got0, got1;

    vecs[0]  = '{0, 1'b1, 8'h00, 8'h01, 8'h00};
    vecs[1]  = '{1, 1'b1, 8'h01, 8'h02, 8'h00};
    vecs[2]  = '{0, 1'b1, 8'h10, 8'h77, 8'h00};
    vecs[3]  = '{0, 1'b1, 8'h20, 8'hA5, 8'h00};
    vecs[4]  = '{0, 1'b0, 8'h20, 8'h00, 8'hA5};
    vecs[5]  = '{1, 1'b1, 8'h80, 8'h5A, 8'h00};
    vecs[6]  = '{1, 1'b0, 8'h80, 8'h00, 8'h5A};
    vecs[7]  = '{0, 1'b0, 8'h80, 8'h00, 8'h5A};
    vecs[8]  = '{1, 1'b0, 8'h20, 8'h00, 8'hA5};
    vecs[9]  = '{0, 1'b1, 8'hFE, 8'hC3, 8'h00};
    vecs[10] = '{0, 1'b0, 8'hFE, 8'h00, 8'hC3};
    vecs[11] = '{1, 1'b0, 8'h00, 8'h00, 8'h01};

    driveA(0, 1'b0, 1'b0, 8'h00, 8'h00);
    driveA(1, 1'b0, 1'b0, 8'h00, 8'h00);
    busB.req0 = 0; busB.we0 = 0; busB.addr0 = 0; busB.wdata0 = 0;
    busB.req1 = 0; busB.we1 = 0; busB.addr1 = 0; busB.wdata1 = 0;

    // Reset state.
    #1 reset = 1'b1;
    @(posedge clock); #1;
    checkOutput("reset outputs A", {busA.ack0, busA.ack1, busA.rdata0, busA.rdata1, busA.memWrite,
                busA.memRead, busA.endereco, busA.escreveDado} == '0, 1);
    checkOutput("reset outputs B", {busB.ack0, busB.ack1, busB.rdata0, busB.rdata1, busB.memWrite,
                busB.memRead, busB.endereco, busB.escreveDado} == '0, 1);
    checkOutput("reset state A", 32'(dutA.state_q), 32'(IDLE));
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("idle memRead", busA.memRead, 0);

    // Preload RAM contents through the arbiter.
    for (int i = 0; i < 3; i++) applyStimulus(vecs[i]);

    // An async reset in the middle of a write's ACCESS cycle aborts the write.
    @(posedge clock); #1;
    driveA(0, 1'b1, 1'b1, 8'h10, 8'h55);
    @(posedge clock); #1;
    checkOutput("midreset memWrite before", busA.memWrite, 1);
    checkOutput("midreset endereco", busA.endereco, 8'h10);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset memWrite async drop", busA.memWrite, 0);
    driveA(0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clock); #1;
    checkOutput("midreset no ack", busA.ack0, 0);
    reset = 1'b0;
    applyStimulus('{0, 1'b0, 8'h10, 8'h00, 8'h77});

    // Main vector table.
    for (int i = 3; i < 12; i++) begin
      applyStimulus(vecs[i]);
      if (i == 4) checkOutput("rdata1 unchanged", busA.rdata1, 8'h00);
    end

    // Both ports hold their requests. Grants alternate 0,1,0,1.
    pulseReset();
    pushA(0, 1'b0, 8'h01); pushA(0, 1'b0, 8'h01);
    pushA(1, 1'b0, 8'h02); pushA(1, 1'b0, 8'h02);
    driveA(0, 1'b1, 1'b0, 8'h00, 8'h00);
    driveA(1, 1'b1, 1'b0, 8'h01, 8'h00);
    for (int k = 0; k < 4; k++) begin
      cycles = 0;
      port = 9;
      while (port == 9 && cycles < 10) begin
        @(posedge clock); #1;
        cycles++;
        if (busA.ack0) port = 0;
        else if (busA.ack1) port = 1;
      end
      checkOutput($sformatf("rr grant %0d", k), port, k % 2);
    end
    driveA(0, 1'b0, 1'b0, 8'h00, 8'h00);
    driveA(1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Fixed priority: port 0 always wins and port 1 is never acknowledged.
    for (int k = 0; k < 4; k++) qB0.push_back('{1'b0, 8'h01});
    @(posedge clock); #1;
    busB.req0 = 1; busB.addr0 = 8'h00;
    busB.req1 = 1; busB.addr1 = 8'h01;
    ack0Seen = 0;
    cycles = 0;
    while (ack0Seen < 4 && cycles < 40) begin
      @(posedge clock); #1;
      cycles++;
      if (busB.ack0) ack0Seen++;
    end
    busB.req0 = 0; busB.req1 = 0;
    checkOutput("fixed prio ack0 count", ack0Seen, 4);
    checkOutput("fixed prio ack1 count", ackB1Count, 0);

    // Simultaneous write 0x3C@0xFF on port 0 and read 0xFF on port 1.
    pulseReset();
    pushA(0, 1'b1, 8'h00);
    pushA(1, 1'b0, 8'h3C);
    driveA(0, 1'b1, 1'b1, 8'hFF, 8'h3C);
    driveA(1, 1'b1, 1'b0, 8'hFF, 8'h00);
    firstPort = 9;
    got0 = 0; got1 = 0;
    cycles = 0;
    while (!(got0 && got1) && cycles < 20) begin
      @(posedge clock); #1;
      cycles++;
      if (firstPort == 9 && (busA.ack0 || busA.ack1)) firstPort = busA.ack1 ? 1 : 0;
      if (busA.ack0) begin got0 = 1; driveA(0, 1'b0, 1'b0, 8'h00, 8'h00); end
      if (busA.ack1) begin got1 = 1; driveA(1, 1'b0, 1'b0, 8'h00, 8'h00); end
    end
    checkOutput("w/r same addr first grant", firstPort, 0);
    checkOutput("w/r same addr both acked", {got0, got1}, 2'b11);

    // Port 1 keeps requesting after its ack. A req0 pulse during RESP is ignored.
    pushA(1, 1'b0, 8'h02); pushA(1, 1'b0, 8'h02);
    @(posedge clock); #1;
    driveA(1, 1'b1, 1'b0, 8'h01, 8'h00);
    cycles = 0;
    got1 = 0;
    while (!got1 && cycles < 10) begin
      @(posedge clock); #1;
      cycles++;
      got1 = busA.ack1;
    end
    checkOutput("held req first ack", got1, 1);
    driveA(0, 1'b1, 1'b0, 8'h00, 8'h00);
    #3 driveA(0, 1'b0, 1'b0, 8'h00, 8'h00);
    cycles = 0;
    got1 = 0;
    while (!got1 && cycles < 10) begin
      @(posedge clock); #1;
      cycles++;
      got1 = busA.ack1;
    end
    checkOutput("held req back-to-back spacing", got1 ? cycles : 99, 3);
    driveA(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (5) @(posedge clock);
    #1;

    checkOutput("scoreboard A0 drained", qA0.size(), 0);
    checkOutput("scoreboard A1 drained", qA1.size(), 0);
    checkOutput("scoreboard B0 drained", qB0.size(), 0);
    checkOutput("fixed prio ack1 never", ackB1Count, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
